// File: rtl/skew_feed_controller_if.sv
// Stream and control bundle between the input buffer, layer sequencer and skew_feed_controller.
interface skew_feed_controller_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int N           = 4,
   parameter int COUNT_WIDTH = 16
);
   logic                       start;
   logic [COUNT_WIDTH-1:0]     num_rows;
   logic                       in_valid;
   logic                       in_ready;
   logic [N*DATA_WIDTH-1:0]    in_data;
   logic                       skew_en;
   logic [N*DATA_WIDTH-1:0]    skew_din;
   logic                       busy;
   logic                       done;
   logic [COUNT_WIDTH-1:0]     stall_cycles;

   modport master (
      output start, num_rows, in_valid, in_data,
      input  in_ready, skew_en, skew_din, busy, done, stall_cycles
   );

   modport slave (
      input  start, num_rows, in_valid, in_data,
      output in_ready, skew_en, skew_din, busy, done, stall_cycles
   );
endinterface

// File: rtl/skew_feed_controller.sv
// Feeds num_rows input rows into the skew register bank, then N-1 zero rows to drain it, then pulses done.
// Optional stall counter enabled by defining SKEW_FEED_STALL_CNT_EN.
module skew_feed_controller #(
   parameter int DATA_WIDTH  = 16,
   parameter int N           = 4,
   parameter int COUNT_WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   skew_feed_controller_if.slave bus
);

   localparam int                 FLUSH_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((N > 1) ? N - 2 : 0);

   typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [COUNT_WIDTH-1:0] row_cnt;
   logic [COUNT_WIDTH-1:0] rows_q;
   logic [FLUSH_W-1:0]     flush_cnt;
   logic                   start_accept;
   logic                   handshake;
   logic                   last_row;

   assign start_accept = (state == IDLE) && bus.start;
   assign handshake    = (state == FEED) && bus.in_valid;
   assign last_row     = (row_cnt == rows_q - COUNT_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = (bus.num_rows != '0) ? FEED : DONE;
         FEED:    if (handshake && last_row) state_next = (N > 1) ? FLUSH : DONE;
         FLUSH:   if (flush_cnt == FLUSH_LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // in_data is forwarded combinationally on the handshake; it is never captured here.
   always_comb begin
      bus.in_ready = 1'b0;
      bus.skew_en  = 1'b0;
      bus.skew_din = '0;
      bus.done     = 1'b0;
      bus.busy     = (state != IDLE);
      case (state)
         FEED: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               bus.skew_en  = 1'b1;
               bus.skew_din = bus.in_data;
            end
         end
         FLUSH:   bus.skew_en = 1'b1;
         DONE:    bus.done    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt   <= '0;
         rows_q    <= '0;
         flush_cnt <= '0;
      end else begin
         if (start_accept) begin
            rows_q  <= bus.num_rows;
            row_cnt <= '0;
         end else if (handshake) begin
            row_cnt <= row_cnt + COUNT_WIDTH'(1);
         end
         if (state == FLUSH) flush_cnt <= flush_cnt + FLUSH_W'(1);
         else                flush_cnt <= '0;
      end
   end

`ifdef SKEW_FEED_STALL_CNT_EN
   logic [COUNT_WIDTH-1:0] stall_q;

   // Saturating count of FEED cycles without a valid row; kept after DONE for readout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= '0;
      else if (start_accept)
         stall_q <= '0;
      else if ((state == FEED) && !bus.in_valid && (stall_q != '1))
         stall_q <= stall_q + COUNT_WIDTH'(1);
   end

   assign bus.stall_cycles = stall_q;
`else
   assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_skew_feed_controller.sv
// Self-checking bench for skew_feed_controller: directed test-plan cases plus randomized transfers
// checked cycle by cycle against a transfer-level timeline model.
module tb_skew_feed_controller;

   localparam int DW  = 16;
   localparam int N   = 4;
   localparam int CW  = 6;
   localparam int NW  = N * DW;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   skew_feed_controller_if #(.DATA_WIDTH(DW), .N(N), .COUNT_WIDTH(CW)) bus ();

   skew_feed_controller #(.DATA_WIDTH(DW), .N(N), .COUNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic          v;
      logic [NW-1:0] d;
      logic          rdy;
      logic          en;
      logic [NW-1:0] din;
      logic          dn;
      logic          bsy;
   } step_t;

   int            vectors        = 0;
   int            miscompares    = 0;
   int            exp_stall_hold = 0;
   bit            wave_check     = 1'b0;
   logic [NW-1:0] rows_q [$];
   int            stalls_q [$];

   // Downstream skew bank model: lane i is delayed by i enabled cycles.
   logic [DW-1:0] sk [N][N];

   always @(posedge clk) begin
      if (bus.skew_en === 1'b1) begin
         for (int i = 1; i < N; i++) begin
            for (int j = N - 1; j > 0; j--) sk[i][j] <= sk[i][j-1];
            sk[i][0] <= bus.skew_din[i*DW +: DW];
         end
      end
   end

   function automatic logic [NW-1:0] rand_row();
      logic [NW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   function automatic logic [NW-1:0] ramp_row(input int base);
      logic [NW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(base + i);
      return r;
   endfunction

   function automatic int sat_stall(input int c);
      return (c > SAT) ? SAT : c;
   endfunction

   function automatic step_t mk(input logic v, input logic [NW-1:0] d, input logic rdy,
                                input logic en, input logic [NW-1:0] din, input logic dn,
                                input logic bsy);
      step_t s;
      s.v = v; s.d = d; s.rdy = rdy; s.en = en; s.din = din; s.dn = dn; s.bsy = bsy;
      return s;
   endfunction

   task automatic check_output(input string tag, input logic [NW-1:0] observed,
                               input logic [NW-1:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic idle_check(input string tag);
      check_output({tag, ".in_ready"}, bus.in_ready, '0);
      check_output({tag, ".skew_en"},  bus.skew_en,  '0);
      check_output({tag, ".skew_din"}, bus.skew_din, '0);
      check_output({tag, ".done"},     bus.done,     '0);
      check_output({tag, ".busy"},     bus.busy,     '0);
   endtask

   // One transfer: start in cycle 0, then follow the expected timeline built from rows_q/stalls_q.
   // reset_at pulls rst_n low in that cycle; start_at re-pulses start with num_rows=9 there.
   task automatic apply_stimulus(input int nrows, input int reset_at, input int start_at);
      step_t         tl [$];
      step_t         s;
      int            total_stalls = 0;
      int            run_stall    = 0;
      int            done_seen    = -1;
      int            exp_done_cycle;
      int            exp_stall;
      int            lane;
      bit            aborted      = 1'b0;
      logic [NW-1:0] r0;

      for (int r = 0; r < nrows; r++) begin
         for (int k = 0; k < stalls_q[r]; k++) tl.push_back(mk(1'b0, rand_row(), 1'b1, 1'b0, '0, 1'b0, 1'b1));
         total_stalls += stalls_q[r];
         tl.push_back(mk(1'b1, rows_q[r], 1'b1, 1'b1, rows_q[r], 1'b0, 1'b1));
      end
      if (nrows != 0)
         for (int k = 0; k < N - 1; k++) tl.push_back(mk(1'b1, rand_row(), 1'b0, 1'b1, '0, 1'b0, 1'b1));
      tl.push_back(mk(1'($urandom), rand_row(), 1'b0, 1'b0, '0, 1'b1, 1'b1));
      tl.push_back(mk(1'b1, rand_row(), 1'b0, 1'b0, '0, 1'b0, 1'b0));
      exp_done_cycle = (nrows == 0) ? 1 : nrows + total_stalls + N;

      bus.start    = 1'b1;
      bus.num_rows = CW'(nrows);
      bus.in_valid = 1'($urandom);
      bus.in_data  = rand_row();
      @(negedge clk);
      idle_check("start_cycle");
      check_output("stall_hold", bus.stall_cycles, NW'(exp_stall_hold));
      @(posedge clk); #1;

      for (int k = 1; k <= tl.size() && !aborted; k++) begin
         s            = tl[k-1];
         bus.start    = (k == start_at);
         bus.num_rows = (k == start_at) ? CW'(9) : CW'($urandom);
         bus.in_valid = s.v;
         bus.in_data  = s.d;
         if (k == reset_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            idle_check("reset_mid");
            check_output("reset_mid.stall", bus.stall_cycles, '0);
            @(posedge clk); #1;
            rst_n     = 1'b1;
            bus.start = 1'b0;
            repeat (2) begin
               @(negedge clk);
               idle_check("after_reset");
               @(posedge clk); #1;
            end
            exp_stall_hold = 0;
            aborted        = 1'b1;
         end else begin
            @(negedge clk);
`ifdef SKEW_FEED_STALL_CNT_EN
            exp_stall = sat_stall(run_stall);
`else
            exp_stall = 0;
`endif
            check_output("in_ready",     bus.in_ready,     NW'(s.rdy));
            check_output("skew_en",      bus.skew_en,      NW'(s.en));
            check_output("skew_din",     bus.skew_din,     s.din);
            check_output("done",         bus.done,         NW'(s.dn));
            check_output("busy",         bus.busy,         NW'(s.bsy));
            check_output("stall_cycles", bus.stall_cycles, NW'(exp_stall));
            if (bus.done === 1'b1 && done_seen < 0) done_seen = k;
            if (wave_check && k >= 2 && k <= N) begin
               lane = k - 1;
               r0   = rows_q[0];
               check_output("wavefront", NW'(sk[lane][lane-1]), NW'(r0[lane*DW +: DW]));
            end
            if (s.rdy && !s.v) run_stall++;
            @(posedge clk); #1;
         end
      end

      if (!aborted) begin
         check_output("done_cycle", NW'(done_seen), NW'(exp_done_cycle));
`ifdef SKEW_FEED_STALL_CNT_EN
         exp_stall_hold = sat_stall(run_stall);
`else
         exp_stall_hold = 0;
`endif
      end
   endtask

   initial begin
      int nr;

      rst_n        = 1'b0;
      bus.start    = 1'b1;
      bus.in_valid = 1'b1;
      bus.num_rows = CW'(5);
      bus.in_data  = rand_row();
      repeat (3) begin
         @(negedge clk);
         idle_check("reset_hold");
         check_output("reset_hold.stall", bus.stall_cycles, '0);
      end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      idle_check("post_reset");
      @(posedge clk); #1;

      $display("[TB] 3 rows, no stalls");
      rows_q   = '{ramp_row(1), ramp_row(2), ramp_row(3)};
      stalls_q = '{0, 0, 0};
      wave_check = 1'b1;
      apply_stimulus(3, -1, -1);
      wave_check = 1'b0;

      $display("[TB] 3 rows, 2 stall cycles after row 1");
      stalls_q = '{0, 2, 0};
      apply_stimulus(3, -1, -1);

      $display("[TB] zero rows");
      rows_q.delete();
      stalls_q.delete();
      apply_stimulus(0, -1, -1);

      $display("[TB] start during FEED is ignored");
      rows_q   = '{ramp_row(4), ramp_row(5), ramp_row(6)};
      stalls_q = '{0, 0, 0};
      apply_stimulus(3, -1, 2);

      $display("[TB] reset in second FLUSH cycle, then a 1-row transfer");
      apply_stimulus(3, 5, -1);
      rows_q   = '{ramp_row(7)};
      stalls_q = '{0};
      apply_stimulus(1, -1, -1);

      $display("[TB] long stall saturates the stall counter");
      rows_q   = '{rand_row(), rand_row()};
      stalls_q = '{70, 0};
      apply_stimulus(2, -1, -1);

      $display("[TB] randomized transfers");
      for (int t = 0; t < 12; t++) begin
         nr = $urandom_range(0, 6);
         rows_q.delete();
         stalls_q.delete();
         for (int r = 0; r < nr; r++) begin
            rows_q.push_back(rand_row());
            stalls_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         end
         apply_stimulus(nr, -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
